move_resolver: RTL and testbench
================================

MOVE_RESOLVER -- requirements
Module: move_resolver

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset; the polarity and synchronicity are fixed.
REQ-002 Ports (name, direction, width, meaning):
- clock  in  1  sole clock; all state changes on its posedge
- reset  in  1  synchronous, active-high
- new_move  in  1  request level, held high by the game controller while it waits
- player  in  1  0 = black, 1 = white
- cur_x  in  3  target column
- cur_y  in  3  target row
- rd_addr  out  6  board read address, {y,x}
- rd_data  in  2  board cell; 00 empty, 01 black, 10 white; valid one cycle after rd_addr
- wr_en  out  1  board write strobe
- wr_addr  out  6  board write address, {y,x}
- wr_data  out  2  board write value
- nm_done  out  1  move resolution complete
- ack  out  1  1 = legal move committed; qualified by nm_done
- flip_total  out  6  discs flipped by the last move; qualified by nm_done

Function
REQ-003 SHALL latch player, cur_x and cur_y in IDLE on the first cycle new_move=1, and ignore later changes on those inputs until IDLE is re-entered.
REQ-004 States SHALL be: IDLE, RD_TGT, CHK_TGT, SCAN_RD, SCAN_CHK, FLIP, NEXT_DIR, WR_TGT, DONE.
REQ-005 RD_TGT SHALL drive rd_addr to the target cell; CHK_TGT SHALL go to DONE with ack=0 if rd_data!=00, else start direction 0.
REQ-006 Directions 0..7 SHALL be (dx,dy) = N(0,-1), NE(+1,-1), E(+1,0), SE(+1,+1), S(0,+1), SW(-1,+1), W(-1,0), NW(-1,-1), processed in that order.
REQ-007 Per direction, SCAN_RD/SCAN_CHK SHALL step one cell per read; a step leaving 0..7 on either axis SHALL end the direction invalid, with no address wrap.
REQ-008 Scan outcome:
- opponent cell: increment the 3-bit run count, continue
- own cell with count>=1: direction valid
- own cell with count=0, or empty cell: direction invalid
REQ-009 For a valid direction, FLIP SHALL write the player colour to the count cells starting one step from the target, one write per cycle.
REQ-010 FLIP SHALL add count to flip_total; it SHALL never write the target or the closing own cell.
REQ-011 NEXT_DIR SHALL clear count and advance the direction; after direction 7 it SHALL go to WR_TGT if flip_total>0, else to DONE with ack=0.
REQ-012 WR_TGT SHALL write the player colour to the target for exactly one cycle, then go to DONE with ack=1.
REQ-013 wr_data SHALL be 01 for black and 10 for white; wr_en SHALL be high only in FLIP and WR_TGT.
REQ-014 DONE SHALL hold nm_done=1 with stable ack and flip_total while new_move=1.
REQ-015 DONE SHALL return to IDLE the cycle after new_move=0 is sampled; nm_done SHALL be high for at least one cycle per request.
REQ-016 If new_move drops before DONE, the resolution SHALL complete and commit normally; DONE then lasts one cycle.
REQ-017 flip_total SHALL be cleared on leaving IDLE; its maximum value is 48 and it SHALL not overflow.
REQ-018 A request SHALL complete in at most 2 + 8*(2*7+6+1) + 1 cycles plus the DONE hold.

Reset
REQ-019 reset=1 SHALL force IDLE and clear nm_done, ack, wr_en, flip_total, count and the latched request, from any state, on the next posedge.
REQ-020 A reset during FLIP SHALL stop all further writes; writes already committed SHALL not be undone.
REQ-021 rd_addr SHALL be 0 in IDLE and after reset.

Verification
REQ-022 Start board: (3,3)=W, (4,4)=W, (3,4)=B, (4,3)=B; black at (2,3) -> one write addr 27 = 01, then one write addr 26 = 01; nm_done=1, ack=1, flip_total=1.
REQ-023 Same board, black at (3,3) (occupied) -> nm_done=1, ack=0, flip_total=0, wr_en never asserted.
REQ-024 Start board, white at (0,0) -> all 8 directions scanned, ack=0, no writes.
REQ-025 Wrap check: empty board except (0,4)=W and (1,4)=B; black at (7,3) -> ack=0, no write to address 32 or 33.
REQ-026 Multi-direction: W at (1,1)..(6,1) and (1,0); B at (7,1) and (2,0); black at (0,1) -> E flips 6 and NE... only valid runs flip, total flip_total=6; reset asserted on the 3rd FLIP write -> exactly 2 flipped cells remain, nm_done=0, state IDLE.
REQ-027 Handshake: hold new_move=1 for 10 cycles after nm_done rises -> nm_done and ack stable for 10 cycles; drop new_move -> nm_done=0 next cycle, and new_move re-asserted then starts a new request.

Source files
------------

// File: rtl/move_resolver.sv
// Othello move resolver: checks a target cell, scans the eight directions for
// capturable runs, flips them through the board write port, then claims the target.
module move_resolver (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_move,
  input  logic       player,
  input  logic [2:0] cur_x,
  input  logic [2:0] cur_y,
  output logic [5:0] rd_addr,
  input  logic [1:0] rd_data,
  output logic       wr_en,
  output logic [5:0] wr_addr,
  output logic [1:0] wr_data,
  output logic       nm_done,
  output logic       ack,
  output logic [5:0] flip_total
);

  typedef enum logic [3:0] {
    IDLE, RD_TGT, CHK_TGT, SCAN_RD, SCAN_CHK, FLIP, NEXT_DIR, WR_TGT, DONE
  } state_t;

  state_t     state, state_n;
  logic       ply;
  logic [2:0] tx, ty;
  logic [2:0] dir;
  logic [2:0] cnt;
  logic [2:0] px, py;
  logic [2:0] fx, fy;
  logic [2:0] frem;

  function automatic logic signed [1:0] dir_dx(input logic [2:0] d);
    case (d)
      3'd0, 3'd4:        dir_dx = 2'sd0;
      3'd1, 3'd2, 3'd3:  dir_dx = 2'sd1;
      default:           dir_dx = -2'sd1;
    endcase
  endfunction

  function automatic logic signed [1:0] dir_dy(input logic [2:0] d);
    case (d)
      3'd2, 3'd6:        dir_dy = 2'sd0;
      3'd3, 3'd4, 3'd5:  dir_dy = 2'sd1;
      default:           dir_dy = -2'sd1;
    endcase
  endfunction

  function automatic logic signed [4:0] step_sum(input logic [2:0] pos,
                                                 input logic signed [1:0] d);
    logic signed [4:0] de;
    de = {{3{d[1]}}, d};
    step_sum = $signed({2'b00, pos}) + de;
  endfunction

  // A step is off-board when the signed sum leaves 0..7; the low bits are never reused then.
  function automatic logic step_oob(input logic [2:0] pos, input logic signed [1:0] d);
    logic signed [4:0] s;
    s = step_sum(pos, d);
    step_oob = (s[4:3] != 2'b00);
  endfunction

  function automatic logic [2:0] step_pos(input logic [2:0] pos, input logic signed [1:0] d);
    logic signed [4:0] s;
    s = step_sum(pos, d);
    step_pos = s[2:0];
  endfunction

  logic signed [1:0] dx, dy;
  logic              oob;
  logic [2:0]        sx, sy;
  logic [1:0]        own, opp;

  always_comb begin
    dx  = dir_dx(dir);
    dy  = dir_dy(dir);
    oob = step_oob(px, dx) | step_oob(py, dy);
    sx  = step_pos(px, dx);
    sy  = step_pos(py, dy);
    own = ply ? 2'b10 : 2'b01;
    opp = ply ? 2'b01 : 2'b10;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (new_move) state_n = RD_TGT;
      RD_TGT:   state_n = CHK_TGT;
      CHK_TGT:  state_n = (rd_data != 2'b00) ? DONE : SCAN_RD;
      SCAN_RD:  state_n = oob ? NEXT_DIR : SCAN_CHK;
      SCAN_CHK: begin
        if (rd_data == opp)                      state_n = SCAN_RD;
        else if (rd_data == own && cnt != 3'd0)  state_n = FLIP;
        else                                     state_n = NEXT_DIR;
      end
      FLIP:     if (frem == 3'd1) state_n = NEXT_DIR;
      NEXT_DIR: begin
        if (dir != 3'd7)             state_n = SCAN_RD;
        else if (flip_total != 6'd0) state_n = WR_TGT;
        else                         state_n = DONE;
      end
      WR_TGT:   state_n = DONE;
      DONE:     if (!new_move) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    rd_addr = 6'd0;
    wr_addr = 6'd0;
    wr_data = 2'b00;
    wr_en   = 1'b0;
    nm_done = (state == DONE);
    case (state)
      RD_TGT:  rd_addr = {ty, tx};
      SCAN_RD: if (!oob) rd_addr = {sy, sx};
      FLIP: begin
        wr_en   = !reset;
        wr_addr = {fy, fx};
        wr_data = own;
      end
      WR_TGT: begin
        wr_en   = !reset;
        wr_addr = {ty, tx};
        wr_data = own;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ply        <= 1'b0;
      tx         <= 3'd0;
      ty         <= 3'd0;
      dir        <= 3'd0;
      cnt        <= 3'd0;
      px         <= 3'd0;
      py         <= 3'd0;
      fx         <= 3'd0;
      fy         <= 3'd0;
      frem       <= 3'd0;
      flip_total <= 6'd0;
      ack        <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (new_move) begin
          ply        <= player;
          tx         <= cur_x;
          ty         <= cur_y;
          flip_total <= 6'd0;
          ack        <= 1'b0;
        end
        CHK_TGT: begin
          dir <= 3'd0;
          cnt <= 3'd0;
          px  <= tx;
          py  <= ty;
        end
        SCAN_RD: if (!oob) begin
          px <= sx;
          py <= sy;
        end
        SCAN_CHK: begin
          if (rd_data == opp) begin
            cnt <= cnt + 3'd1;
          end else if (rd_data == own && cnt != 3'd0) begin
            // Flipping restarts one step out from the target along the same direction.
            fx   <= step_pos(tx, dx);
            fy   <= step_pos(ty, dy);
            frem <= cnt;
          end
        end
        FLIP: begin
          fx         <= step_pos(fx, dx);
          fy         <= step_pos(fy, dy);
          frem       <= frem - 3'd1;
          flip_total <= flip_total + 6'd1;
        end
        NEXT_DIR: begin
          cnt <= 3'd0;
          dir <= dir + 3'd1;
          px  <= tx;
          py  <= ty;
        end
        WR_TGT: ack <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_move_resolver.sv
// Scoreboard bench for move_resolver: board model memory, expected results queued
// at request issue and compared by a monitor when nm_done rises.
module tb_move_resolver;

  logic       clock = 1'b0;
  logic       reset;
  logic       new_move;
  logic       player;
  logic [2:0] cur_x, cur_y;
  logic [5:0] rd_addr;
  logic [1:0] rd_data;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [1:0] wr_data;
  logic       nm_done;
  logic       ack;
  logic [5:0] flip_total;

  move_resolver dut (
    .clock(clock), .reset(reset), .new_move(new_move), .player(player),
    .cur_x(cur_x), .cur_y(cur_y), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .nm_done(nm_done),
    .ack(ack), .flip_total(flip_total)
  );

  always #5 clock = ~clock;

  logic [1:0] mem [64];
  logic [7:0] wlog [$];

  always @(posedge clock) begin
    rd_data <= mem[rd_addr];
    if (wr_en) begin
      mem[wr_addr] = wr_data;
      wlog.push_back({wr_addr, wr_data});
    end
  end

  typedef struct packed {
    logic       ack;
    logic [5:0] ft;
    logic [3:0] nw;
    logic [7:0] w0;
    logic [7:0] wl;
  } exp_t;

  exp_t expq [$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (nm_done && !prev_done) begin
      if (expq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("ack", int'(ack), int'(e.ack));
        chk("flip_total", int'(flip_total), int'(e.ft));
        chk("write_count", wlog.size(), int'(e.nw));
        if (e.nw != 0 && wlog.size() == int'(e.nw)) begin
          chk("first_write", int'(wlog[0]), int'(e.w0));
          chk("last_write", int'(wlog[$]), int'(e.wl));
        end
      end
      wlog.delete();
    end
    prev_done = nm_done;
  end

  task automatic clear_board();
    for (int i = 0; i < 64; i++) mem[i] = 2'b00;
  endtask

  task automatic start_board();
    clear_board();
    mem[27] = 2'b10;  // (3,3) W
    mem[36] = 2'b10;  // (4,4) W
    mem[35] = 2'b01;  // (3,4) B
    mem[28] = 2'b01;  // (4,3) B
  endtask

  task automatic multi_board();
    clear_board();
    for (int x = 1; x <= 6; x++) mem[8 + x] = 2'b10;
    mem[1]  = 2'b10;
    mem[15] = 2'b01;
    mem[2]  = 2'b01;
  endtask

  task automatic push_exp(input logic a, input logic [5:0] ft, input logic [3:0] nw,
                          input logic [7:0] w0, input logic [7:0] wl);
    exp_t x;
    x.ack = a; x.ft = ft; x.nw = nw; x.w0 = w0; x.wl = wl;
    expq.push_back(x);
  endtask

  task automatic issue(input logic p, input logic [2:0] x, input logic [2:0] y);
    @(negedge clock);
    player = p; cur_x = x; cur_y = y; new_move = 1'b1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!nm_done && cyc < 300) begin
      @(negedge clock);
      cyc++;
    end
    chk("done_timeout", int'(nm_done), 1);
  endtask

  task automatic release_req();
    new_move = 1'b0;
    @(negedge clock);
    chk("nm_done_drop", int'(nm_done), 0);
  endtask

  initial begin
    int cyc;
    int n;
    int guard;
    reset = 1'b1; new_move = 1'b0; player = 1'b0; cur_x = 3'd0; cur_y = 3'd0;
    clear_board();
    repeat (3) @(negedge clock);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_nm_done", int'(nm_done), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_flip_total", int'(flip_total), 0);
    reset = 1'b0;

    // Black at (2,3): flips (3,3) then claims (2,3); later input changes are ignored.
    start_board();
    push_exp(1'b1, 6'd1, 4'd2, {6'd27, 2'b01}, {6'd26, 2'b01});
    issue(1'b0, 3'd2, 3'd3);
    @(negedge clock);
    player = 1'b1; cur_x = 3'd0; cur_y = 3'd0;
    wait_done(cyc);
    release_req();
    chk("cell27", int'(mem[27]), 1);
    chk("cell26", int'(mem[26]), 1);

    // Occupied target.
    start_board();
    push_exp(1'b0, 6'd0, 4'd0, 8'd0, 8'd0);
    issue(1'b0, 3'd3, 3'd3);
    wait_done(cyc);
    release_req();

    // White in the corner: no legal capture; request dropped early, DONE lasts one cycle.
    start_board();
    push_exp(1'b0, 6'd0, 4'd0, 8'd0, 8'd0);
    issue(1'b1, 3'd0, 3'd0);
    @(negedge clock);
    new_move = 1'b0;
    wait_done(cyc);
    @(negedge clock);
    chk("done_one_cycle", int'(nm_done), 0);

    // Row-wrap guard: stepping east off column 7 must not reach (0,4).
    clear_board();
    mem[32] = 2'b10;
    mem[33] = 2'b01;
    push_exp(1'b0, 6'd0, 4'd0, 8'd0, 8'd0);
    issue(1'b0, 3'd7, 3'd3);
    wait_done(cyc);
    release_req();
    chk("wrap_cell32", int'(mem[32]), 2);

    // Long east run with a dead-end NE run.
    multi_board();
    push_exp(1'b1, 6'd6, 4'd7, {6'd9, 2'b01}, {6'd8, 2'b01});
    issue(1'b0, 3'd0, 3'd1);
    wait_done(cyc);
    chk("latency_bound", int'(cyc <= 172), 1);
    release_req();
    for (int x = 1; x <= 6; x++) chk("multi_flip", int'(mem[8 + x]), 1);
    chk("multi_ne_untouched", int'(mem[1]), 2);

    // Same move, reset while the third flip write is presented.
    multi_board();
    wlog.delete();
    issue(1'b0, 3'd0, 3'd1);
    n = 0; guard = 0;
    while (n < 3 && guard < 300) begin
      @(negedge clock);
      guard++;
      if (wr_en) n++;
    end
    chk("flip_wait", n, 3);
    reset = 1'b1; new_move = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_flip_writes", wlog.size(), 2);
    chk("rst_flip_nm_done", int'(nm_done), 0);
    chk("rst_flip_ack", int'(ack), 0);
    chk("rst_flip_total", int'(flip_total), 0);
    chk("rst_flip_rd_addr", int'(rd_addr), 0);
    chk("rst_flip_cell9", int'(mem[9]), 1);
    chk("rst_flip_cell10", int'(mem[10]), 1);
    for (int x = 3; x <= 6; x++) chk("rst_flip_kept", int'(mem[8 + x]), 2);
    wlog.delete();

    // Handshake hold, release, immediate re-request.
    start_board();
    push_exp(1'b1, 6'd1, 4'd2, {6'd27, 2'b01}, {6'd26, 2'b01});
    issue(1'b0, 3'd2, 3'd3);
    wait_done(cyc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("hold_nm_done", int'(nm_done), 1);
      chk("hold_ack", int'(ack), 1);
      chk("hold_flip_total", int'(flip_total), 1);
    end
    new_move = 1'b0;
    @(negedge clock);
    chk("hold_drop", int'(nm_done), 0);
    push_exp(1'b0, 6'd0, 4'd0, 8'd0, 8'd0);
    player = 1'b0; cur_x = 3'd3; cur_y = 3'd3; new_move = 1'b1;
    wait_done(cyc);
    release_req();

    repeat (2) @(negedge clock);
    chk("exp_queue_empty", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
